clk_period_meter: RTL
=====================

Name: clk_period_meter

Overview:
Measures a slow, divided clock generated inside the design (for example a divide-by-4 output) in units of sys_clk cycles. It reports the period and high time of the measured clock, so divider outputs can be checked in-system.
The measured clock is treated as an asynchronous level. It is synchronised, edge-detected and timed by a small FSM.
Single-shot and continuous modes are supported, and a timeout covers a stuck clock.

Parameters:
CNT_W, 16, width of the cycle counter and of the period/high_time outputs
SYNC_STAGES, 2, number of flops in the meas_clk synchroniser (>=2)
TIMEOUT_CYC, 1000, sys_clk cycles without the expected edge before the measurement aborts (must be <= 2^CNT_W-1)

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
sys_rst_n  in  1  asynchronous active-low reset
meas_clk  in  1  clock under measurement, sampled as data
start  in  1  one-cycle request to begin a measurement; ignored while busy
cont_mode  in  1  1 = keep measuring back-to-back periods after the first; sampled every cycle
busy  out  1  high whenever the FSM is not in IDLE
period  out  CNT_W  sys_clk cycles between two consecutive rising edges of meas_clk
high_time  out  CNT_W  sys_clk cycles from a rising edge to the following falling edge
valid  out  1  one-cycle pulse when period/high_time have just been updated
timeout  out  1  one-cycle pulse when a measurement is aborted

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; synchroniser and edge register 0; state IDLE; cnt 0. Reset mid-measurement aborts immediately, with no valid or timeout pulse.
- Front end:
  - meas_clk passes through SYNC_STAGES flops, then one delay flop.
  - rise = sync & ~dly; fall = ~sync & dly.
  - Both edges see the same latency, so differences between edges are exact.
- FSM states:
  - IDLE: on start, go to WAIT_RISE and set cnt<=0.
  - WAIT_RISE: each cycle cnt<=cnt+1. On rise, go to MEASURE and set cnt<=1, hi_seen<=0.
  - MEASURE: each cycle cnt<=cnt+1. On the first fall, high_time_r<=cnt and hi_seen<=1. On rise:
    - period<=cnt; high_time<=high_time_r (0 if hi_seen=0); valid<=1.
    - If cont_mode=1, stay in MEASURE with cnt<=1 and hi_seen<=0; this rise becomes the new reference edge.
    - Otherwise go to IDLE.
- Result: for a reference rise at cycle t0, a fall at tf and the next rise at t1: period = t1-t0 and high_time = tf-t0.
- Timeout: in WAIT_RISE or MEASURE, if cnt==TIMEOUT_CYC and rise is not present, then at the next edge timeout<=1 and the FSM goes to IDLE. period/high_time keep their last valid values.
- Simultaneous rise and cnt==TIMEOUT_CYC: rise wins, so the measurement completes normally.
- Output timing: valid and timeout are registered, never high together, and high for exactly one cycle.
- start: ignored when busy=1. start in the same cycle that the FSM returns to IDLE is ignored; it is honoured from the following cycle.
- Width: cnt never exceeds TIMEOUT_CYC, so no wrap-around occurs.
- Mode change: cont_mode dropping to 0 during MEASURE ends the run after the next completed period.

Decomposition:
- Shared package: FSM state enum (IDLE, WAIT_RISE, MEASURE) and the default CNT_W/TIMEOUT_CYC constants.
- One natural sub-module, sync_edge_det: SYNC_STAGES synchroniser plus delay flop, with outputs level, rise and fall. It is reused wherever an asynchronous level needs edge detection.
- Cycle counter and FSM stay in the top level.

Test Plan:
- Divide-by-4 source on meas_clk (2 cycles high, 2 low), start pulse, cont_mode=0 -> one valid pulse with period=4 and high_time=2; busy returns to 0 the next cycle.
- Same source with cont_mode=1 -> valid every 4 cycles with period=4 and high_time=2 each time. Drop cont_mode -> exactly one more valid, then busy=0.
- meas_clk held 0, TIMEOUT_CYC=16 -> timeout pulses 17 cycles after start is sampled; period/high_time unchanged and valid never asserted.
- Asymmetric source (3 high, 7 low) -> period=10, high_time=3. A second start pulse while busy is ignored: only one valid.
- sys_rst_n asserted mid-MEASURE with cont_mode=1 -> all outputs 0 at once. After release, the FSM stays IDLE until a new start.
- Period equal to TIMEOUT_CYC, so rise coincides with cnt==TIMEOUT_CYC -> valid with period=TIMEOUT_CYC and no timeout.

Source files
------------

// File: rtl/clk_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_period_meter_pkg
// Shared definitions for the clock period meter: FSM state encoding and the
// default sizing constants used by the top level.
// -----------------------------------------------------------------------------
package clk_period_meter_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 1000;

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// -----------------------------------------------------------------------------
// clk_period_meter_sync_edge_det
// Brings an asynchronous level into the i_clk domain through SYNC_STAGES flops,
// then adds one delay flop so that rising and falling edges are detected with
// identical latency.
//
// Ports:
//   i_clk    in   clock
//   i_rst_n  in   asynchronous active-low reset
//   i_async  in   asynchronous level to be sampled
//   o_level  out  synchronised level
//   o_rise   out  one-cycle pulse on a synchronised 0->1 transition
//   o_fall   out  one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module clk_period_meter_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_dly;

endmodule

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
// Measures the period and high time of a slow clock (meas_clk) in units of
// sys_clk cycles. meas_clk is treated as an asynchronous level, synchronised and
// edge-detected, then timed by a three-state FSM with single-shot and
// continuous modes and a timeout for a stuck clock.
//
// Ports:
//   sys_clk    in   system clock, all logic on its rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   meas_clk   in   clock under measurement, sampled as data
//   start      in   one-cycle request to begin a measurement (ignored if busy)
//   cont_mode  in   1 = keep measuring back-to-back periods
//   busy       out  high whenever the FSM is not idle
//   period     out  sys_clk cycles between consecutive rising edges
//   high_time  out  sys_clk cycles from a rising edge to the next falling edge
//   valid      out  one-cycle pulse when period/high_time were just updated
//   timeout    out  one-cycle pulse when a measurement was aborted
// -----------------------------------------------------------------------------
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             meas_clk,
  input  logic             start,
  input  logic             cont_mode,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_unused_level;

  state_t           r_state,   w_state_next;
  logic [CNT_W-1:0] r_cnt,     w_cnt_next;
  logic [CNT_W-1:0] r_hi_cnt,  w_hi_cnt_next;
  logic             r_hi_seen, w_hi_seen_next;
  logic [CNT_W-1:0] r_period,  w_period_next;
  logic [CNT_W-1:0] r_high,    w_high_next;
  logic             r_valid,   w_valid_next;
  logic             r_timeout, w_timeout_next;

  clk_period_meter_sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_async (meas_clk),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Only the edges matter for timing; the level is not needed here.
  assign w_unused_level = w_level;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi_cnt  <= '0;
      r_hi_seen <= 1'b0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_hi_cnt  <= w_hi_cnt_next;
      r_hi_seen <= w_hi_seen_next;
      r_period  <= w_period_next;
      r_high    <= w_high_next;
      r_valid   <= w_valid_next;
      r_timeout <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_hi_cnt_next  = r_hi_cnt;
    w_hi_seen_next = r_hi_seen;
    w_period_next  = r_period;
    w_high_next    = r_high;
    w_valid_next   = 1'b0;
    w_timeout_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_WAIT_RISE;
          w_cnt_next   = '0;
        end
      end

      ST_WAIT_RISE: begin
        // A rise arriving together with the timeout count still wins.
        if (w_rise) begin
          w_state_next   = ST_MEASURE;
          w_cnt_next     = CNT_ONE;
          w_hi_seen_next = 1'b0;
        end else if (r_cnt == TIMEOUT_VAL) begin
          w_timeout_next = 1'b1;
          w_state_next   = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      ST_MEASURE: begin
        if (w_rise) begin
          w_period_next = r_cnt;
          w_high_next   = r_hi_seen ? r_hi_cnt : '0;
          w_valid_next  = 1'b1;
          if (cont_mode) begin
            // This rise is the reference edge of the next period.
            w_cnt_next     = CNT_ONE;
            w_hi_seen_next = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (r_cnt == TIMEOUT_VAL) begin
          w_timeout_next = 1'b1;
          w_state_next   = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
          // cnt already equals cycles since the reference rise.
          if (w_fall && !r_hi_seen) begin
            w_hi_cnt_next  = r_cnt;
            w_hi_seen_next = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign period    = r_period;
  assign high_time = r_high;
  assign valid     = r_valid;
  assign timeout   = r_timeout;

endmodule
